fazyrv_wb_arb: RTL and testbench

//  Two-master -> one-slave Wishbone (classic) arbiter directly downstream of the FazyRV top.

---
 rtl/fazyrv_wb_arb_pkg.sv | 19 +
 rtl/fazyrv_wb_arb_wdt.sv | 32 +++
 rtl/fazyrv_wb_arb.sv | 132 +++++++++++++
 tb/tb_fazyrv_wb_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fazyrv_wb_arb_pkg.sv
// Shared types and constants for the FazyRV imem/dmem Wishbone arbiter.
package fazyrv_wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT_I,
    ARB_GNT_D,
    ARB_RECOV
  } arb_state_t;

  localparam logic [3:0] IMEM_SEL = 4'hF;

  // Counter width for a watchdog of length t. A disabled watchdog still
  // needs a 1-bit vector so that the declaration stays legal.
  function automatic int unsigned wdt_width(input int unsigned t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/fazyrv_wb_arb_wdt.sv
// Saturating ack-timeout counter. It is cleared while clr_i is high and counts while en_i is high.
// expire_o is high in the cycle where the count reaches TIMEOUT-1.
module fazyrv_wb_arb_wdt
  import fazyrv_wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW   = wdt_width(TIMEOUT);
  localparam int unsigned LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [CW-1:0] cnt;

  // The count holds at LAST, so it never wraps around to zero.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in)
      cnt <= '0;
    else if (clr_i || (TIMEOUT == 0))
      cnt <= '0;
    else if (en_i && (cnt != CW'(LAST)))
      cnt <= cnt + 1'b1;
  end

  assign expire_o = (TIMEOUT != 0) && en_i && (cnt == CW'(LAST));

endmodule

// File: rtl/fazyrv_wb_arb.sv
// Round-robin arbiter that connects the FazyRV instruction and data Wishbone masters to one
// classic slave. A grant is held until ack or abort, and an optional watchdog forces an
// error-ack.
module fazyrv_wb_arb
  import fazyrv_wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 64,
  parameter bit          DMEM_PRIO = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_in,

  input  logic        wb_imem_cyc_i,
  input  logic        wb_imem_stb_i,
  input  logic [31:0] wb_imem_adr_i,
  output logic [31:0] wb_imem_dat_o,
  output logic        wb_imem_ack_o,

  input  logic        wb_dmem_cyc_i,
  input  logic        wb_dmem_stb_i,
  input  logic        wb_dmem_we_i,
  input  logic [3:0]  wb_dmem_be_i,
  input  logic [31:0] wb_dmem_adr_i,
  input  logic [31:0] wb_dmem_dat_i,
  output logic [31:0] wb_dmem_dat_o,
  output logic        wb_dmem_ack_o,

  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        err_o
);

  arb_state_t state;
  logic       last_d;   // 1: the most recent grant went to dmem
  logic       req_i, req_d;
  logic       gnt_i, gnt_d, in_gnt;
  logic       expire, forced, bus_en;
  logic       gnt_master_cyc;
  logic [31:0] rd_dat;

  assign req_i  = wb_imem_cyc_i & wb_imem_stb_i;
  assign req_d  = wb_dmem_cyc_i & wb_dmem_stb_i;
  assign gnt_i  = (state == ARB_GNT_I);
  assign gnt_d  = (state == ARB_GNT_D);
  assign in_gnt = gnt_i | gnt_d;

  fazyrv_wb_arb_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk_i    (clk_i),
    .rst_in   (rst_in),
    .clr_i    (~in_gnt),
    .en_i     (in_gnt),
    .expire_o (expire)
  );

  // A genuine ack in the expiry cycle wins. The watchdog only fires when the slave is silent.
  assign forced = expire & ~wb_ack_i;
  assign bus_en = in_gnt & ~forced;
  assign err_o  = forced;

  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_sel_o = '0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    if (bus_en) begin
      if (gnt_d) begin
        wb_cyc_o = wb_dmem_cyc_i;
        wb_stb_o = wb_dmem_stb_i;
        wb_we_o  = wb_dmem_we_i;
        wb_sel_o = wb_dmem_be_i;
        wb_adr_o = wb_dmem_adr_i;
        wb_dat_o = wb_dmem_dat_i;
      end else begin
        wb_cyc_o = wb_imem_cyc_i;
        wb_stb_o = wb_imem_stb_i;
        wb_sel_o = IMEM_SEL;
        wb_adr_o = wb_imem_adr_i;
      end
    end
  end

  // Read data is fanned out to both masters. It is zeroed on a forced error-ack.
  assign rd_dat        = bus_en ? wb_dat_i : '0;
  assign wb_imem_dat_o = rd_dat;
  assign wb_dmem_dat_o = rd_dat;
  assign wb_imem_ack_o = gnt_i & (wb_ack_i | expire);
  assign wb_dmem_ack_o = gnt_d & (wb_ack_i | expire);

  assign gnt_master_cyc = gnt_d ? wb_dmem_cyc_i : wb_imem_cyc_i;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state  <= ARB_IDLE;
      last_d <= ~DMEM_PRIO;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (req_i && req_d)
            state <= last_d ? ARB_GNT_I : ARB_GNT_D;
          else if (req_d)
            state <= ARB_GNT_D;
          else if (req_i)
            state <= ARB_GNT_I;
        end
        ARB_GNT_I, ARB_GNT_D: begin
          // Leaving a grant always passes through IDLE or RECOV.
          // This keeps stb low for at least one cycle between transfers.
          if (wb_ack_i || expire || !gnt_master_cyc) begin
            last_d <= gnt_d;
            state  <= forced ? ARB_RECOV : ARB_IDLE;
          end
        end
        ARB_RECOV: begin
          if (!wb_ack_i)
            state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fazyrv_wb_arb.sv
// Scenario bench for fazyrv_wb_arb. It drives two instances (TIMEOUT=4 and TIMEOUT=3) from
// the same stimulus, and a queue of expected transfers is checked against each master ack.
module tb_fazyrv_wb_arb;

  typedef struct packed {
    logic        is_d;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cyc, i_stb;
  logic [31:0] i_adr;
  logic        d_cyc, d_stb, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_adr, d_wdat;
  logic [31:0] s_dat;
  logic        s_ack;

  logic [31:0] i_rdat, d_rdat, m_adr, m_wdat;
  logic        i_ack, d_ack, m_cyc, m_stb, m_we, err;
  logic [3:0]  m_sel;

  logic [31:0] b_i_rdat, b_d_rdat, b_adr, b_wdat;
  logic        b_i_ack, b_d_ack, b_cyc, b_stb, b_we, b_err;
  logic [3:0]  b_sel;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fazyrv_wb_arb #(.TIMEOUT(4), .DMEM_PRIO(1'b1)) dut_a (
    .clk_i(clk), .rst_in(rst_n),
    .wb_imem_cyc_i(i_cyc), .wb_imem_stb_i(i_stb), .wb_imem_adr_i(i_adr),
    .wb_imem_dat_o(i_rdat), .wb_imem_ack_o(i_ack),
    .wb_dmem_cyc_i(d_cyc), .wb_dmem_stb_i(d_stb), .wb_dmem_we_i(d_we), .wb_dmem_be_i(d_be),
    .wb_dmem_adr_i(d_adr), .wb_dmem_dat_i(d_wdat), .wb_dmem_dat_o(d_rdat), .wb_dmem_ack_o(d_ack),
    .wb_cyc_o(m_cyc), .wb_stb_o(m_stb), .wb_we_o(m_we), .wb_sel_o(m_sel),
    .wb_adr_o(m_adr), .wb_dat_o(m_wdat), .wb_dat_i(s_dat), .wb_ack_i(s_ack), .err_o(err)
  );

  fazyrv_wb_arb #(.TIMEOUT(3), .DMEM_PRIO(1'b1)) dut_b (
    .clk_i(clk), .rst_in(rst_n),
    .wb_imem_cyc_i(i_cyc), .wb_imem_stb_i(i_stb), .wb_imem_adr_i(i_adr),
    .wb_imem_dat_o(b_i_rdat), .wb_imem_ack_o(b_i_ack),
    .wb_dmem_cyc_i(d_cyc), .wb_dmem_stb_i(d_stb), .wb_dmem_we_i(d_we), .wb_dmem_be_i(d_be),
    .wb_dmem_adr_i(d_adr), .wb_dmem_dat_i(d_wdat), .wb_dmem_dat_o(b_d_rdat), .wb_dmem_ack_o(b_d_ack),
    .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_we_o(b_we), .wb_sel_o(b_sel),
    .wb_adr_o(b_adr), .wb_dat_o(b_wdat), .wb_dat_i(s_dat), .wb_ack_i(s_ack), .err_o(b_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    i_cyc = 0; i_stb = 0; i_adr = '0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_be = '0; d_adr = '0; d_wdat = '0;
    s_ack = 0; s_dat = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_in();
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    logic [73:0] v;
    logic [69:0] w;
    rst_n = 0;
    clear_in();
    i_cyc = 1; i_stb = 1; i_adr = 32'h80;
    d_cyc = 1; d_stb = 1; d_we = 1; d_be = 4'hF; d_adr = 32'h100; d_wdat = 32'hDEADBEEF;
    s_ack = 1; s_dat = 32'hFFFF_FFFF;
    step();
    #1;
    v = {m_cyc, m_stb, m_we, m_sel, m_adr, m_wdat, i_ack, d_ack, err};
    n_chk++;
    if (v !== '0) $display("FAIL reset_state: got %h exp 0", v); else n_pass++;

    s_ack = 0; i_cyc = 0; i_stb = 0;
    rst_n = 1;
    step();
    #1;
    w = {m_cyc, m_we, m_sel, m_adr, m_wdat};
    n_chk++;
    if (w !== {1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF})
      $display("FAIL dmem_write_grant: got %h", w);
    else n_pass++;

    #1 rst_n = 0;
    #1;
    v = {m_cyc, m_stb, m_we, m_sel, m_adr, m_wdat, i_ack, d_ack, err};
    n_chk++;
    if (v !== '0) $display("FAIL async_reset_mid_grant: got %h exp 0", v); else n_pass++;

    step();
    rst_n = 1;
    #1;
    n_chk++;
    if (m_cyc !== 1'b0) $display("FAIL idle_after_release: cyc got %b exp 0", m_cyc); else n_pass++;
    step();
    #1;
    n_chk++;
    if (m_cyc !== 1'b1) $display("FAIL regrant_after_reset: cyc got %b exp 1", m_cyc); else n_pass++;
    clear_in();
    step();
  endtask

  task automatic test_single_read();
    exp_t e;
    logic [69:0] w;
    do_reset();
    exp_q.push_back('{1'b0, 32'h80, 32'h0000_0013});
    i_cyc = 1; i_stb = 1; i_adr = 32'h80;
    #1;
    n_chk++;
    if (m_cyc !== 1'b0) $display("FAIL arb_latency: cyc got %b exp 0", m_cyc); else n_pass++;

    step();
    #1;
    w = {m_cyc, m_stb, m_we, m_sel, m_adr[31:0], m_wdat[31:0]} & {70{1'b1}};
    n_chk++;
    if ({m_cyc, m_stb, m_we, m_sel, m_adr, m_wdat} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0})
      $display("FAIL imem_bus_mirror: got %h", w);
    else n_pass++;

    step();
    #1;
    n_chk++;
    if ({i_ack, d_ack} !== 2'b00) $display("FAIL imem_no_early_ack: got %b exp 00", {i_ack, d_ack});
    else n_pass++;

    step();
    s_ack = 1; s_dat = 32'h0000_0013;
    #1;
    n_chk++;
    if ({i_ack, d_ack} !== 2'b10) $display("FAIL imem_ack_route: got %b exp 10", {i_ack, d_ack});
    else n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (i_rdat !== e.dat) $display("FAIL imem_rdata: got %h exp %h", i_rdat, e.dat); else n_pass++;

    step();
    s_ack = 0; i_cyc = 0; i_stb = 0;
    #1;
    n_chk++;
    if ({m_cyc, i_ack} !== 2'b00) $display("FAIL imem_release: got %b exp 00", {m_cyc, i_ack});
    else n_pass++;
  endtask

  task automatic test_contention();
    exp_t e;
    int   grants = 0;
    int   gap = 0;
    do_reset();
    i_cyc = 1; i_stb = 1; i_adr = 32'h200;
    d_cyc = 1; d_stb = 1; d_we = 0; d_be = 4'hF; d_adr = 32'h300;
    exp_q.push_back('{1'b1, 32'h300, 32'h300 ^ 32'h5A5A_0000});
    exp_q.push_back('{1'b0, 32'h200, 32'h200 ^ 32'h5A5A_0000});
    exp_q.push_back('{1'b1, 32'h300, 32'h300 ^ 32'h5A5A_0000});
    exp_q.push_back('{1'b0, 32'h200, 32'h200 ^ 32'h5A5A_0000});
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      step();
      s_ack = 0;
      #1;
      if (m_stb === 1'b1) begin
        e = exp_q.pop_front();
        n_chk++;
        if (m_adr !== e.adr) $display("FAIL rr_order grant %0d: adr got %h exp %h", grants, m_adr, e.adr);
        else n_pass++;
        if (grants > 0) begin
          n_chk++;
          if (gap < 1) $display("FAIL rr_gap grant %0d: idle cycles got %0d exp >=1", grants, gap);
          else n_pass++;
        end
        s_dat = m_adr ^ 32'h5A5A_0000;
        s_ack = 1;
        #1;
        n_chk++;
        if ({i_ack, d_ack} !== (e.is_d ? 2'b01 : 2'b10))
          $display("FAIL rr_ack_route grant %0d: got %b", grants, {i_ack, d_ack});
        else n_pass++;
        n_chk++;
        if ((e.is_d ? d_rdat : i_rdat) !== e.dat)
          $display("FAIL rr_rdata grant %0d: got %h exp %h", grants, e.is_d ? d_rdat : i_rdat, e.dat);
        else n_pass++;
        grants++;
        gap = 0;
      end else begin
        gap++;
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      $display("FAIL rr_timeout: %0d grants outstanding exp 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
    step();
    clear_in();
    step();
  endtask

  task automatic test_watchdog();
    exp_t e;
    do_reset();
    exp_q.push_back('{1'b1, 32'h400, 32'h0});
    d_cyc = 1; d_stb = 1; d_we = 0; d_be = 4'hF; d_adr = 32'h400;
    s_dat = 32'h1234_5678;
    for (int c = 1; c <= 4; c++) begin
      step();
      #1;
      if (c < 4) begin
        n_chk++;
        if ({m_cyc, d_ack, err} !== 3'b100)
          $display("FAIL wdt_wait cycle %0d: cyc/ack/err got %b exp 100", c, {m_cyc, d_ack, err});
        else n_pass++;
      end else begin
        n_chk++;
        if ({m_cyc, m_stb, d_ack, err} !== 4'b0011)
          $display("FAIL wdt_expire: cyc/stb/ack/err got %b exp 0011", {m_cyc, m_stb, d_ack, err});
        else n_pass++;
        e = exp_q.pop_front();
        n_chk++;
        if (d_rdat !== e.dat) $display("FAIL wdt_rdata: got %h exp %h", d_rdat, e.dat); else n_pass++;
      end
    end
    step();
    clear_in();
    i_cyc = 1; i_stb = 1; i_adr = 32'h480;
    s_ack = 1; s_dat = 32'hBAD0_BAD0;
    #1;
    n_chk++;
    if ({i_ack, d_ack, m_cyc, err} !== 4'b0000)
      $display("FAIL recov_late_ack: got %b exp 0000", {i_ack, d_ack, m_cyc, err});
    else n_pass++;
    step();
    #1;
    n_chk++;
    if ({i_ack, d_ack, m_cyc, err} !== 4'b0000)
      $display("FAIL recov_hold: got %b exp 0000", {i_ack, d_ack, m_cyc, err});
    else n_pass++;
    step();
    s_ack = 0;
    #1;
    n_chk++;
    if (m_cyc !== 1'b0) $display("FAIL recov_exit_cycle: cyc got %b exp 0", m_cyc); else n_pass++;
    step();
    #1;
    n_chk++;
    if (m_cyc !== 1'b0) $display("FAIL recov_idle: cyc got %b exp 0", m_cyc); else n_pass++;
    step();
    #1;
    n_chk++;
    if ({m_cyc, m_adr} !== {1'b1, 32'h480})
      $display("FAIL grant_after_recov: got %b/%h exp 1/480", m_cyc, m_adr);
    else n_pass++;
    clear_in();
    step();
  endtask

  task automatic test_abort();
    exp_t e;
    do_reset();
    i_cyc = 1; i_stb = 1; i_adr = 32'h500;
    step();
    d_cyc = 1; d_stb = 1; d_we = 1; d_be = 4'h3; d_adr = 32'h600; d_wdat = 32'hA5;
    #1;
    n_chk++;
    if ({m_cyc, m_adr} !== {1'b1, 32'h500}) $display("FAIL abort_imem_grant: got %b/%h", m_cyc, m_adr);
    else n_pass++;
    step();
    i_cyc = 0; i_stb = 0;
    #1;
    n_chk++;
    if ({m_cyc, i_ack} !== 2'b00) $display("FAIL abort_bus_drop: got %b exp 00", {m_cyc, i_ack});
    else n_pass++;
    step();
    #1;
    n_chk++;
    if (m_cyc !== 1'b0) $display("FAIL abort_idle_gap: cyc got %b exp 0", m_cyc); else n_pass++;
    step();
    exp_q.push_back('{1'b1, 32'h600, 32'h7777_0000});
    #1;
    n_chk++;
    if ({m_cyc, m_we, m_sel, m_adr, m_wdat} !== {1'b1, 1'b1, 4'h3, 32'h600, 32'hA5})
      $display("FAIL abort_dmem_grant: got %b/%b/%h/%h/%h", m_cyc, m_we, m_sel, m_adr, m_wdat);
    else n_pass++;
    s_ack = 1; s_dat = 32'h7777_0000;
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if ({i_ack, d_ack, d_rdat} !== {1'b0, 1'b1, e.dat})
      $display("FAIL abort_dmem_ack: got %b%b/%h exp 01/%h", i_ack, d_ack, d_rdat, e.dat);
    else n_pass++;
    step();
    clear_in();
    step();
  endtask

  task automatic test_ack_wdt_coincide();
    exp_t e;
    do_reset();
    exp_q.push_back('{1'b1, 32'h700, 32'hCAFE_BABE});
    d_cyc = 1; d_stb = 1; d_we = 0; d_be = 4'hF; d_adr = 32'h700;
    step();
    #1;
    n_chk++;
    if ({b_cyc, b_d_ack, b_err} !== 3'b100) $display("FAIL coin_c1: got %b exp 100", {b_cyc, b_d_ack, b_err});
    else n_pass++;
    step();
    #1;
    n_chk++;
    if ({b_cyc, b_d_ack, b_err} !== 3'b100) $display("FAIL coin_c2: got %b exp 100", {b_cyc, b_d_ack, b_err});
    else n_pass++;
    step();
    s_ack = 1; s_dat = 32'hCAFE_BABE;
    #1;
    n_chk++;
    if ({b_cyc, b_d_ack, b_err} !== 3'b110)
      $display("FAIL coin_ack_err: cyc/ack/err got %b exp 110", {b_cyc, b_d_ack, b_err});
    else n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (b_d_rdat !== e.dat) $display("FAIL coin_rdata: got %h exp %h", b_d_rdat, e.dat); else n_pass++;
    step();
    clear_in();
    #1;
    n_chk++;
    if ({b_cyc, b_err} !== 2'b00) $display("FAIL coin_idle: got %b exp 00", {b_cyc, b_err}); else n_pass++;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_in();
    rst_n = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_watchdog();
    test_abort();
    test_ack_wdt_coincide();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
